instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Inverse of the control decoder: turns a stream of mnemonic commands (op code + register fields + imm)
//  into 32-bit MIPS R-type/I-type instruction words. Writes them sequentially into instruction memory.
//  Sits between a testbench/host command source and the IM write port.
//  Used to load programs for the single-cycle datapath without a hex file.
// PARAMETERS
//  ADDR_W  32            IM byte-address width
//  BASE    32'h0000_3000 first word address written after start
//  DEPTH   1024          max words per load session; reaching it ends the session
// PORTS
//  clk        in   1       rising-edge clock (single clock domain)
//  rst        in   1       synchronous, active-high reset
//  start      in   1       begin a load session (sampled in IDLE or DONE only)
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       block accepts a command this cycle
//  cmd_op     in   4       mnemonic: 0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU,
//                          8 ADDI, 9 ADDIU, A ANDI, B ORI, C LUI, D-F illegal
//  cmd_rs     in   5       source register
//  cmd_rt     in   5       target register (I-type destination)
//  cmd_rd     in   5       R-type destination
//  cmd_imm    in   16      immediate (I-type only)
//  cmd_last   in   1       this command ends the session
//  im_we      out  1       IM write strobe, one cycle per word
//  im_addr    out  ADDR_W  IM byte address of the word being written
//  im_wdata   out  32      encoded instruction
//  count      out  ADDR_W  words written in the current session
//  done       out  1       session finished, held until the next start
//  err        out  1       sticky: illegal cmd_op seen this session
// BEHAVIOUR
//  Reset: state=IDLE.
//   - Strobe/status outputs to 0: cmd_ready, im_we, im_addr, im_wdata, count, done, err.
//   - Internal write pointer to BASE.
//  Handshake: command accepted on a cycle where cmd_valid & cmd_ready.
//   - cmd_ready = (state==RUN).
//   - Throughput is 1 command per cycle.
//  States:
//   IDLE -start-> RUN: pointer=BASE, count=0, err=0.
//   RUN: each accepted command is encoded and registered.
//   RUN -> DONE: the cycle after accepting a command with cmd_last=1.
//   RUN -> DONE: the cycle after accepting the command that makes count==DEPTH (legal write).
//   DONE -> RUN on start (restart): done=0, pointer=BASE, count=0, err=0.
//  Latency: command accepted in cycle N -> im_we=1 with im_addr/im_wdata in cycle N+1.
//   - Pointer increments by 4 on each legal write.
//   - count increments on the same edge that raises im_we.
//   - Pointer wraps modulo 2^ADDR_W with no flag.
//  Encoding, R-type: {6'h00, rs, rt, rd, 5'b0, funct}.
//   - funct: ADDU 21, SUBU 23, AND 24, OR 25, XOR 26, NOR 27, SLT 2A, SLTU 2B (hex).
//  Encoding, I-type: {opcode, rs, rt, imm}.
//   - opcode: ADDI 08, ADDIU 09, ANDI 0C, ORI 0D, LUI 0F (hex).
//   - LUI forces the rs field to 0.
//   - Unused input fields are ignored (cmd_rd on I-type, cmd_imm on R-type).
//  Illegal cmd_op (D-F): command is still accepted.
//   - No write (im_we stays 0); count and pointer unchanged; err=1, sticky.
//   - If cmd_last=1 the session still ends.
//  im_we is 0 in every cycle without a legal accepted command.
//   - im_addr/im_wdata hold their last value.
//  Boundary and corner cases:
//   - start while in RUN is ignored.
//   - cmd_valid outside RUN is ignored.
//   - cmd_last on the DEPTH-th word gives a single transition to DONE.
//  rst mid-session: next cycle is the reset state. A pending write is dropped (im_we=0).
// TESTING
//  1 start; ADDU rs=1 rt=2 rd=3 -> next cycle im_we=1, im_addr=0x3000, im_wdata=0x00221821, count=1.
//  2 ORI rs=0 rt=8 imm=0x1234, then LUI rs=5 rt=1 imm=0xABCD last=1
//    -> 0x34081234 @0x3000, 0x3C01ABCD @0x3004, then done=1, cmd_ready=0.
//  3 Back-to-back: 8 commands with cmd_valid held high -> 8 consecutive im_we pulses.
//    Addresses 0x3000..0x301C; count=8.
//  4 cmd_op=0xE between two legal ops -> no write for it, err=1.
//    Legal ops land at 0x3000 and 0x3004.
//  5 DEPTH=4 build, 6 commands offered -> exactly 4 writes, done=1 after the 4th, cmd_ready drops.
//  6 rst asserted the cycle after an accept -> im_we=0, all outputs at reset values.
//    Then start restarts at 0x3000 with count=0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes mnemonic commands into MIPS R/I-type words
// and writes them sequentially into instruction memory starting at BASE.
module instr_encoder_loader #(
   parameter int                ADDR_W = 32,
   parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(32'h0000_3000),
   parameter int                DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [4:0]        cmd_rs,
   input  logic [4:0]        cmd_rt,
   input  logic [4:0]        cmd_rd,
   input  logic [15:0]       cmd_imm,
   input  logic              cmd_last,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic [ADDR_W-1:0] count,
   output logic              done,
   output logic              err
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_ptr;
   logic              w_acc, w_legal, w_full;
   logic [5:0]        w_fn;
   logic [31:0]       w_word;

   assign cmd_ready = r_state == RUN;
   assign done      = r_state == DONE;
   assign w_acc     = cmd_valid & cmd_ready;
   assign w_legal   = cmd_op < 4'hD;
   assign w_full    = w_legal & (count + 1'b1 == ADDR_W'(DEPTH));

   // funct field for R-type ops, primary opcode for I-type ops
   always_comb begin
      w_fn = 6'h00;
      case (cmd_op)
         4'h0: w_fn = 6'h21;
         4'h1: w_fn = 6'h23;
         4'h2: w_fn = 6'h24;
         4'h3: w_fn = 6'h25;
         4'h4: w_fn = 6'h26;
         4'h5: w_fn = 6'h27;
         4'h6: w_fn = 6'h2A;
         4'h7: w_fn = 6'h2B;
         4'h8: w_fn = 6'h08;
         4'h9: w_fn = 6'h09;
         4'hA: w_fn = 6'h0C;
         4'hB: w_fn = 6'h0D;
         4'hC: w_fn = 6'h0F;
         default: w_fn = 6'h00;
      endcase
   end

   assign w_word = cmd_op[3] ? {w_fn, (cmd_op == 4'hC) ? 5'd0 : cmd_rs, cmd_rt, cmd_imm}
                             : {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, w_fn};

   always_comb begin
      w_next = r_state;
      if (r_state != RUN)
         w_next = start ? RUN : r_state;
      else if (w_acc & (cmd_last | w_full))
         w_next = DONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_ptr    <= BASE;
         count    <= '0;
         im_we    <= 1'b0;
         im_addr  <= '0;
         im_wdata <= '0;
         err      <= 1'b0;
      end else begin
         r_state <= w_next;
         im_we   <= w_acc & w_legal;
         if (r_state != RUN && start) begin
            r_ptr <= BASE;
            count <= '0;
            err   <= 1'b0;
         end else if (w_acc && w_legal) begin
            im_addr  <= r_ptr;
            im_wdata <= w_word;
            r_ptr    <= r_ptr + ADDR_W'(4);
            count    <= count + 1'b1;
         end else if (w_acc) begin
            err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: scoreboard bench for the instruction encoder/loader,
// with a second DEPTH=4 instance for the session-length limit.
module tb_instr_encoder_loader;
   logic        clk = 1'b0;
   logic        rst, start, cmd_valid, cmd_ready, cmd_last, im_we, done, err;
   logic [3:0]  cmd_op;
   logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
   logic [15:0] cmd_imm;
   logic [31:0] im_addr, im_wdata, count;
   logic        d_start, d_valid, d_ready, d_we, d_done, d_err;
   logic [31:0] d_addr, d_wdata, d_count;
   int          errors = 0, checks = 0;
   logic [63:0] sb[$];
   logic [63:0] exp;
   logic [31:0] ptr;

   always #5 clk = ~clk;

   instr_encoder_loader u_dut (
      .clk(clk), .rst(rst), .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
      .cmd_last(cmd_last), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .count(count), .done(done), .err(err)
   );

   instr_encoder_loader #(.DEPTH(4)) u_d4 (
      .clk(clk), .rst(rst), .start(d_start), .cmd_valid(d_valid), .cmd_ready(d_ready),
      .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
      .cmd_last(cmd_last), .im_we(d_we), .im_addr(d_addr), .im_wdata(d_wdata),
      .count(d_count), .done(d_done), .err(d_err)
   );

   function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rs, rt, rd,
                                       input logic [15:0] imm);
      logic [7:0] rf [8] = '{8'h21, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h2A, 8'h2B};
      logic [7:0] io [5] = '{8'h08, 8'h09, 8'h0C, 8'h0D, 8'h0F};
      if (op < 4'd8) return {6'h00, rs, rt, rd, 5'h00, rf[op[2:0]][5:0]};
      return {io[3'(op - 4'd8)][5:0], (op == 4'hC) ? 5'h00 : rs, rt, imm};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // drives one command; wr means a write is expected for it
   task automatic send(input logic [3:0] op, input logic [4:0] rs, rt, rd,
                       input logic [15:0] imm, input logic last, input logic wr);
      cmd_valid = 1'b1;
      cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_imm = imm; cmd_last = last;
      if (wr) begin
         sb.push_back({ptr, enc(op, rs, rt, rd, imm)});
         ptr += 32'd4;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; cmd_valid = 1'b0; d_start = 1'b0; d_valid = 1'b0;
      cmd_op = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0; cmd_imm = '0; cmd_last = 1'b0;
      step(); step();
      rst = 1'b0;
      checks++;
      if ({cmd_ready, im_we, done, err} !== 4'b0) begin
         errors++; $display("FAIL reset_flags got=%b want=0000", {cmd_ready, im_we, done, err});
      end
      checks++;
      if ({im_addr, im_wdata, count} !== 96'h0) begin
         errors++; $display("FAIL reset_data got=%h want=0", {im_addr, im_wdata, count});
      end
      checks++;
      if ({d_ready, d_we, d_done, d_err, d_count} !== 36'h0) begin
         errors++; $display("FAIL reset_d4 got=%h want=0", {d_ready, d_we, d_done, d_err, d_count});
      end
   endtask

   task automatic test_addu();
      start = 1'b1; ptr = 32'h3000; step(); start = 1'b0;
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL start_ready got=%b want=1", cmd_ready); end
      send(4'h0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 1'b1);
      step();
      if (im_we) begin
         checks++; exp = sb.size() ? sb.pop_front() : 'x;
         if ({im_addr, im_wdata} !== exp) begin errors++; $display("FAIL addu_wr got=%h want=%h", {im_addr, im_wdata}, exp); end
      end
      checks++;
      if ({im_we, im_addr, im_wdata, count} !== {1'b1, 32'h3000, 32'h00221821, 32'd1}) begin
         errors++; $display("FAIL addu got we=%b addr=%h data=%h cnt=%0d want 1/3000/00221821/1", im_we, im_addr, im_wdata, count);
      end
      cmd_valid = 1'b0; start = 1'b1; step(); start = 1'b0;
      send(4'h1, 5'd4, 5'd5, 5'd6, 16'hFFFF, 1'b1, 1'b1);
      step();
      if (im_we) begin
         checks++; exp = sb.size() ? sb.pop_front() : 'x;
         if ({im_addr, im_wdata} !== exp) begin errors++; $display("FAIL subu_wr got=%h want=%h", {im_addr, im_wdata}, exp); end
      end
      cmd_valid = 1'b0;
      checks++;
      if ({im_addr, count, done, cmd_ready} !== {32'h3004, 32'd2, 1'b1, 1'b0}) begin
         errors++; $display("FAIL start_in_run got addr=%h cnt=%0d done=%b rdy=%b want 3004/2/1/0", im_addr, count, done, cmd_ready);
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL addu_missing got=%0d want=0", sb.size()); sb.delete(); end
   endtask

   task automatic test_ori_lui();
      start = 1'b1; ptr = 32'h3000; step(); start = 1'b0;
      send(4'hB, 5'd0, 5'd8, 5'd31, 16'h1234, 1'b0, 1'b1);
      step();
      if (im_we) begin
         checks++; exp = sb.size() ? sb.pop_front() : 'x;
         if ({im_addr, im_wdata} !== exp) begin errors++; $display("FAIL ori_wr got=%h want=%h", {im_addr, im_wdata}, exp); end
      end
      checks++;
      if ({im_we, im_addr, im_wdata} !== {1'b1, 32'h3000, 32'h34081234}) begin
         errors++; $display("FAIL ori got we=%b addr=%h data=%h want 1/3000/34081234", im_we, im_addr, im_wdata);
      end
      send(4'hC, 5'd5, 5'd1, 5'd9, 16'hABCD, 1'b1, 1'b1);
      step();
      if (im_we) begin
         checks++; exp = sb.size() ? sb.pop_front() : 'x;
         if ({im_addr, im_wdata} !== exp) begin errors++; $display("FAIL lui_wr got=%h want=%h", {im_addr, im_wdata}, exp); end
      end
      checks++;
      if ({im_we, im_addr, im_wdata} !== {1'b1, 32'h3004, 32'h3C01ABCD}) begin
         errors++; $display("FAIL lui got we=%b addr=%h data=%h want 1/3004/3C01ABCD", im_we, im_addr, im_wdata);
      end
      cmd_valid = 1'b0;
      checks++;
      if ({done, cmd_ready, count} !== {1'b1, 1'b0, 32'd2}) begin
         errors++; $display("FAIL lui_done got done=%b rdy=%b cnt=%0d want 1/0/2", done, cmd_ready, count);
      end
      step();
      checks++;
      if ({im_we, im_addr, im_wdata, done} !== {1'b0, 32'h3004, 32'h3C01ABCD, 1'b1}) begin
         errors++; $display("FAIL hold got we=%b addr=%h data=%h done=%b want 0/3004/3C01ABCD/1", im_we, im_addr, im_wdata, done);
      end
   endtask

   task automatic test_valid_outside_run();
      send(4'h3, 5'd7, 5'd7, 5'd7, 16'h0, 1'b0, 1'b0);
      step();
      cmd_valid = 1'b0;
      checks++;
      if ({im_we, count, done} !== {1'b0, 32'd2, 1'b1}) begin
         errors++; $display("FAIL valid_in_done got we=%b cnt=%0d done=%b want 0/2/1", im_we, count, done);
      end
   endtask

   task automatic test_back_to_back();
      start = 1'b1; ptr = 32'h3000; step(); start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         send(4'((i * 3) % 13), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), i == 7, 1'b1);
         step();
         checks++;
         if (im_we !== 1'b1) begin errors++; $display("FAIL b2b_pulse%0d got=%b want=1", i, im_we); end
         if (im_we) begin
            checks++; exp = sb.size() ? sb.pop_front() : 'x;
            if ({im_addr, im_wdata} !== exp) begin errors++; $display("FAIL b2b_wr%0d got=%h want=%h", i, {im_addr, im_wdata}, exp); end
         end
      end
      cmd_valid = 1'b0;
      checks++;
      if ({im_addr, count, done} !== {32'h301C, 32'd8, 1'b1}) begin
         errors++; $display("FAIL b2b_end got addr=%h cnt=%0d done=%b want 301C/8/1", im_addr, count, done);
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL b2b_missing got=%0d want=0", sb.size()); sb.delete(); end
   endtask

   task automatic test_illegal();
      start = 1'b1; ptr = 32'h3000; step(); start = 1'b0;
      send(4'h2, 5'd10, 5'd11, 5'd12, 16'h0, 1'b0, 1'b1);
      step();
      if (im_we) begin
         checks++; exp = sb.size() ? sb.pop_front() : 'x;
         if ({im_addr, im_wdata} !== exp) begin errors++; $display("FAIL ill_wr0 got=%h want=%h", {im_addr, im_wdata}, exp); end
      end
      send(4'hE, 5'd1, 5'd1, 5'd1, 16'h1, 1'b0, 1'b0);
      step();
      checks++;
      if ({im_we, err, count, cmd_ready} !== {1'b0, 1'b1, 32'd1, 1'b1}) begin
         errors++; $display("FAIL illegal got we=%b err=%b cnt=%0d rdy=%b want 0/1/1/1", im_we, err, count, cmd_ready);
      end
      send(4'hA, 5'd3, 5'd4, 5'd0, 16'h00F0, 1'b1, 1'b1);
      step();
      if (im_we) begin
         checks++; exp = sb.size() ? sb.pop_front() : 'x;
         if ({im_addr, im_wdata} !== exp) begin errors++; $display("FAIL ill_wr1 got=%h want=%h", {im_addr, im_wdata}, exp); end
      end
      cmd_valid = 1'b0;
      checks++;
      if ({im_addr, err, count, done} !== {32'h3004, 1'b1, 32'd2, 1'b1}) begin
         errors++; $display("FAIL ill_sticky got addr=%h err=%b cnt=%0d done=%b want 3004/1/2/1", im_addr, err, count, done);
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL ill_missing got=%0d want=0", sb.size()); sb.delete(); end
      start = 1'b1; step(); start = 1'b0;
      checks++;
      if ({err, count, done, cmd_ready} !== {1'b0, 32'd0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL restart got err=%b cnt=%0d done=%b rdy=%b want 0/0/0/1", err, count, done, cmd_ready);
      end
      send(4'hF, 5'd2, 5'd2, 5'd2, 16'h2, 1'b1, 1'b0);
      step();
      cmd_valid = 1'b0;
      checks++;
      if ({im_we, err, count, done} !== {1'b0, 1'b1, 32'd0, 1'b1}) begin
         errors++; $display("FAIL ill_last got we=%b err=%b cnt=%0d done=%b want 0/1/0/1", im_we, err, count, done);
      end
   endtask

   task automatic test_depth();
      int n = 0;
      cmd_op = 4'h3; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd3; cmd_last = 1'b0;
      d_start = 1'b1; step(); d_start = 1'b0;
      d_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if (i == 6) d_valid = 1'b0;
         step();
         if (d_we) begin
            n++;
            if (n == 4) begin
               checks++;
               if (d_done !== 1'b1) begin errors++; $display("FAIL depth_done4 got=%b want=1", d_done); end
            end
         end
      end
      checks++;
      if (n != 4) begin errors++; $display("FAIL depth_writes got=%0d want=4", n); end
      checks++;
      if ({d_done, d_ready, d_count, d_addr} !== {1'b1, 1'b0, 32'd4, 32'h300C}) begin
         errors++; $display("FAIL depth_end got done=%b rdy=%b cnt=%0d addr=%h want 1/0/4/300C", d_done, d_ready, d_count, d_addr);
      end
   endtask

   task automatic test_reset_mid();
      start = 1'b1; ptr = 32'h3000; step(); start = 1'b0;
      send(4'h9, 5'd6, 5'd7, 5'd0, 16'h8001, 1'b0, 1'b1);
      step();
      if (im_we) begin
         checks++; exp = sb.size() ? sb.pop_front() : 'x;
         if ({im_addr, im_wdata} !== exp) begin errors++; $display("FAIL rst_wr0 got=%h want=%h", {im_addr, im_wdata}, exp); end
      end
      send(4'h8, 5'd1, 5'd2, 5'd0, 16'h0007, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0; cmd_valid = 1'b0;
      checks++;
      if ({cmd_ready, im_we, done, err, im_addr, im_wdata, count} !== 100'h0) begin
         errors++; $display("FAIL rst_mid got rdy=%b we=%b done=%b err=%b addr=%h data=%h cnt=%0d want all 0",
                            cmd_ready, im_we, done, err, im_addr, im_wdata, count);
      end
      start = 1'b1; ptr = 32'h3000; step(); start = 1'b0;
      checks++;
      if ({count, cmd_ready} !== {32'd0, 1'b1}) begin
         errors++; $display("FAIL rst_restart got cnt=%0d rdy=%b want 0/1", count, cmd_ready);
      end
      send(4'h7, 5'd31, 5'd30, 5'd29, 16'h0, 1'b1, 1'b1);
      step();
      if (im_we) begin
         checks++; exp = sb.size() ? sb.pop_front() : 'x;
         if ({im_addr, im_wdata} !== exp) begin errors++; $display("FAIL rst_wr1 got=%h want=%h", {im_addr, im_wdata}, exp); end
      end
      cmd_valid = 1'b0;
      checks++;
      if ({im_addr, count, done} !== {32'h3000, 32'd1, 1'b1}) begin
         errors++; $display("FAIL rst_after got addr=%h cnt=%0d done=%b want 3000/1/1", im_addr, count, done);
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL rst_missing got=%0d want=0", sb.size()); sb.delete(); end
   endtask

   initial begin
      test_reset();
      test_addu();
      test_ori_lui();
      test_valid_outside_run();
      test_back_to_back();
      test_illegal();
      test_depth();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
